// File: rtl/linear_layer_start_bcast_ctrl_if.sv
// ---------------------------------------------------------------------------
// linear_layer_start_bcast_ctrl_if
//   Bundles the signals around the start-token broadcast controller:
//   the producer push side, the per-consumer broadcast side and the
//   controller's view of the external shift-register (SRL) store.
//
//   slave  : the controller's view (takes pushes/reads, drives the SRL).
//   master : the surrounding environment (producer, consumers, SRL).
//
//   if_write/if_din/if_full_n       producer push handshake
//   cons_read/cons_empty_n/cons_dout per-consumer read handshake, shared data
//   srl_we/srl_addr/srl_din/srl_dout SRL control; srl_dout is combinational
//   occupancy                        tokens currently stored
// ---------------------------------------------------------------------------
interface linear_layer_start_bcast_ctrl_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int NUM_CONS   = 4
);
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic [NUM_CONS-1:0]   cons_read;
  logic [NUM_CONS-1:0]   cons_empty_n;
  logic [DATA_WIDTH-1:0] cons_dout;
  logic                  srl_we;
  logic [ADDR_WIDTH-1:0] srl_addr;
  logic [DATA_WIDTH-1:0] srl_din;
  logic [DATA_WIDTH-1:0] srl_dout;
  logic [ADDR_WIDTH:0]   occupancy;

  modport slave (
    input  if_write, if_din, cons_read, srl_dout,
    output if_full_n, cons_empty_n, cons_dout, srl_we, srl_addr, srl_din, occupancy
  );

  modport master (
    output if_write, if_din, cons_read, srl_dout,
    input  if_full_n, cons_empty_n, cons_dout, srl_we, srl_addr, srl_din, occupancy
  );
endinterface

// File: rtl/linear_layer_start_bcast_ctrl.sv
// ---------------------------------------------------------------------------
// linear_layer_start_bcast_ctrl
//   Sequences an external SRL (write at index 0, older entries shift up) as a
//   start-token FIFO whose head is broadcast to NUM_CONS consumers. A token
//   retires only once every consumer has taken it; a consumer that already
//   took the head sees "empty" until the retire.
//
//   ap_clk    rising-edge clock
//   ap_rst_n  synchronous active-low reset
//   bus       linear_layer_start_bcast_ctrl_if.slave (push, broadcast, SRL)
// ---------------------------------------------------------------------------
module linear_layer_start_bcast_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int NUM_CONS   = 4
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  linear_layer_start_bcast_ctrl_if.slave bus
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]       count_q, count_d;
  logic [NUM_CONS-1:0] served_q, served_d;
  logic [NUM_CONS-1:0] empty_n, rd;
  logic                not_empty, full_n, push, pop;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    not_empty = (count_q != '0);
    // Outputs are forced inactive while reset is held, so requests during
    // reset can neither push nor be counted as reads.
    full_n    = ap_rst_n && (count_q < DEPTH_C);
    empty_n   = (ap_rst_n && not_empty) ? ~served_q : '0;
    push      = bus.if_write && full_n;
    rd        = bus.cons_read & empty_n;
    // The head retires in the cycle the last outstanding consumer takes it.
    pop       = not_empty && ((served_q | rd) == '1);
    served_d  = pop ? '0 : (served_q | rd);
    count_d   = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      // Push with pop: the SRL shift moves the new head to the same index.
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      count_q  <= '0;
      served_q <= '0;
    end else begin
      count_q  <= count_d;
      served_q <= served_d;
    end
  end

  // The head (oldest token) sits at index count-1 of the SRL. SRL contents
  // are never cleared: with count=0 no stale entry is reachable.
  assign bus.srl_addr     = not_empty ? ADDR_WIDTH'(count_q - CW'(1)) : '0;
  assign bus.srl_we       = push;
  assign bus.srl_din      = bus.if_din;
  assign bus.cons_dout    = bus.srl_dout;
  assign bus.if_full_n    = full_n;
  assign bus.cons_empty_n = empty_n;
  assign bus.occupancy    = count_q;

endmodule

// File: tb/tb_linear_layer_start_bcast_ctrl.sv
// ---------------------------------------------------------------------------
// tb_linear_layer_start_bcast_ctrl
//   Drives the broadcast controller with directed scenarios and random
//   traffic, modelling the external SRL, and compares every output each
//   cycle with a queue-based reference of the token FIFO.
// ---------------------------------------------------------------------------
module tb_linear_layer_start_bcast_ctrl;
  localparam int DW    = 1;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int NC    = 4;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  linear_layer_start_bcast_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CONS(NC)) bus ();

  linear_layer_start_bcast_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_CONS(NC)
  ) dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus     (bus)
  );

  // External SRL: new entry at index 0, older entries shift up.
  logic [DW-1:0] srl_mem [2**AW];
  always @(posedge ap_clk) begin
    if (bus.srl_we) begin
      for (int i = 2**AW - 1; i > 0; i--) srl_mem[i] <= srl_mem[i-1];
      srl_mem[0] <= bus.srl_din;
    end
  end
  assign bus.srl_dout = srl_mem[bus.srl_addr];

  int total = 0;
  int bad   = 0;

  // Reference: tokens in push order, plus which consumers took the head.
  logic [DW-1:0] tokens [$];
  logic [NC-1:0] taken = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance the reference.
  task automatic cycle(input logic w, input logic [DW-1:0] din,
                       input logic [NC-1:0] rdm, input logic rst);
    logic [NC-1:0] exp_en, rd;
    logic          exp_full, push, pop;
    int            n;
    @(negedge ap_clk);
    ap_rst_n      = rst;
    bus.if_write  = w;
    bus.if_din    = din;
    bus.cons_read = rdm;
    #1;
    n        = tokens.size();
    exp_full = rst && (n < DEPTH);
    exp_en   = (rst && n > 0) ? ~taken : '0;
    push     = w && exp_full;
    check("if_full_n", 32'(bus.if_full_n), 32'(exp_full));
    check("cons_empty_n", 32'(bus.cons_empty_n), 32'(exp_en));
    check("occupancy", 32'(bus.occupancy), n);
    check("srl_we", 32'(bus.srl_we), 32'(push));
    check("srl_addr", 32'(bus.srl_addr), (n > 0) ? n - 1 : 0);
    if (push) check("srl_din", 32'(bus.srl_din), 32'(din));
    if (n > 0) check("cons_dout", 32'(bus.cons_dout), 32'(tokens[0]));
    if (!rst) begin
      tokens.delete();
      taken = '0;
    end else begin
      rd  = rdm & exp_en;
      pop = (n > 0) && ((taken | rd) == '1);
      if (pop) begin
        void'(tokens.pop_front());
        taken = '0;
      end else begin
        taken = taken | rd;
      end
      if (push) tokens.push_back(din);
    end
  endtask

  initial begin
    bus.if_write  = 1'b0;
    bus.if_din    = '0;
    bus.cons_read = '0;
    repeat (2) @(posedge ap_clk);

    // Reset held for 3 cycles, then idle.
    repeat (3) cycle(1'b1, 1'b1, 4'b1111, 1'b0);
    cycle(1'b0, 1'b0, 4'b0000, 1'b1);

    // Fill with 1,0,1,1, then a rejected 5th push.
    cycle(1'b1, 1'b1, 4'b0000, 1'b1);
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);
    cycle(1'b1, 1'b1, 4'b0000, 1'b1);
    cycle(1'b1, 1'b1, 4'b0000, 1'b1);
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);

    // Staggered consumers: 0,2 then 1,3 two cycles later; ignored re-reads.
    cycle(1'b0, 1'b0, 4'b0101, 1'b1);
    cycle(1'b0, 1'b0, 4'b0101, 1'b1);
    cycle(1'b0, 1'b0, 4'b1010, 1'b1);
    cycle(1'b0, 1'b0, 4'b0000, 1'b1);

    // Drop to two tokens, then push and pop together twice.
    cycle(1'b0, 1'b0, 4'b1111, 1'b1);
    cycle(1'b1, 1'b0, 4'b1111, 1'b1);
    cycle(1'b1, 1'b1, 4'b1111, 1'b1);
    cycle(1'b0, 1'b0, 4'b0000, 1'b1);

    // Full boundary: refill to four, then push with pop while full.
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);
    cycle(1'b1, 1'b1, 4'b0000, 1'b1);
    cycle(1'b1, 1'b1, 4'b1111, 1'b1);
    cycle(1'b0, 1'b0, 4'b0000, 1'b1);

    // Reset mid-stream with partial service, then one fresh token.
    cycle(1'b0, 1'b0, 4'b0101, 1'b1);
    cycle(1'b0, 1'b0, 4'b0000, 1'b0);
    cycle(1'b0, 1'b0, 4'b1111, 1'b1);
    cycle(1'b1, 1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 1'b0, 4'b1111, 1'b1);
    cycle(1'b0, 1'b0, 4'b1111, 1'b1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 2000; k++) begin
      logic [NC-1:0] rdm;
      rdm = ($urandom_range(0, 2) == 0) ? {NC{1'b1}} : NC'($urandom);
      cycle(1'($urandom_range(0, 1)), DW'($urandom), rdm, ($urandom_range(0, 99) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
